// File: rtl/fetch_gen2_pkg.sv
// Shared definitions for the fetch_gen2 FETCH stage: opcodes, NOP encoding,
// branch direction constants, BTB counter encodings and fetch-queue entry type.
// Optional feature macro: FETCH_BTB_HYSTERESIS_EN selects 2-bit saturating
// BTB counters; when undefined the BTB keeps a single direction bit per entry.
package fetch_gen2_pkg;

    localparam logic [5:0]  OPCODE_BEQ = 6'b000100;
    localparam logic [5:0]  OPCODE_BNE = 6'b000101;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

`ifdef FETCH_BTB_HYSTERESIS_EN
    localparam int CTR_W = 2;
`else
    localparam int CTR_W = 1;
`endif

    // One fetch-queue slot: fetched address, word and predicted direction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } fq_entry_t;

    function automatic logic is_branch(input logic [31:0] instr);
        return (instr[31:26] == OPCODE_BEQ) || (instr[31:26] == OPCODE_BNE);
    endfunction

`ifdef FETCH_BTB_HYSTERESIS_EN
    // Saturating step of a 2-bit direction counter.
    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken && (cur != STRONG_T)) begin
            nxt = ctr_e'(2'(cur) + 2'd1);
        end else if (!taken && (cur != STRONG_NT)) begin
            nxt = ctr_e'(2'(cur) - 2'd1);
        end
        return nxt;
    endfunction
`endif

endpackage

// File: rtl/fetch_gen2_btb.sv
// fetch_btb: tagged branch target buffer for fetch_gen2.
// Combinational lookup port, synchronous update port, async active-low reset
// clearing only the valid bits. Counter width follows FETCH_BTB_HYSTERESIS_EN.
module fetch_btb
    import fetch_gen2_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_BITS    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rd_pc_i,
    output logic        rd_hit_o,
    output logic        rd_taken_o,
    output logic [31:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_pc_i,
    input  logic [31:0] wr_target_i,
    input  logic        wr_taken_i
);

    localparam int IDX_W  = $clog2(BTB_ENTRIES);
    localparam int TAG_LO = IDX_W + 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]    tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [CTR_W-1:0]       ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic [TAG_BITS-1:0] wr_tag;
    logic [CTR_W-1:0]    ctr_d;

    // Word-offset and upper PC bits take no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc_i, wr_pc_i};

    assign rd_idx = rd_pc_i[TAG_LO-1:2];
    assign rd_tag = rd_pc_i[TAG_LO+TAG_BITS-1:TAG_LO];
    assign wr_idx = wr_pc_i[TAG_LO-1:2];
    assign wr_tag = wr_pc_i[TAG_LO+TAG_BITS-1:TAG_LO];

    // Lookup reads registered storage, so a same-cycle update is not visible.
    assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_taken_o  = rd_hit_o ? ctr_q[rd_idx][CTR_W-1] : NOT_TAKEN;
    assign rd_target_o = target_q[rd_idx];

`ifdef FETCH_BTB_HYSTERESIS_EN
    logic wr_hit;
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Hits step the existing counter; misses allocate in the weak state.
    always_comb begin
        ctr_d = wr_taken_i ? WEAK_T : WEAK_NT;
        if (wr_hit) begin
            ctr_d = ctr_update(ctr_e'(ctr_q[wr_idx]), wr_taken_i);
        end
    end
`else
    // Single-bit history: the last resolved direction, hit or miss alike.
    always_comb begin
        ctr_d = CTR_W'(wr_taken_i);
    end
`endif

    // Valid bits are the only BTB state reset has to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload; rewriting the tag on a hit is harmless and keeps one path.
    always_ff @(posedge clk) begin
        if (wr_en_i && rst_n) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_i;
            ctr_q[wr_idx]    <= ctr_d;
        end
    end

endmodule

// File: rtl/fetch_gen2.sv
// fetch_gen2: FETCH stage with BTB direction/target prediction and a
// FETCH_DEPTH-entry fetch queue decoupling the PC from decode stalls.
// Per-cycle priority: reset > flush > cache_stall > normal fetch.
// Optional feature macro: FETCH_BTB_HYSTERESIS_EN (see fetch_btb).
module fetch_gen2
    import fetch_gen2_pkg::*;
#(
    parameter int          BTB_ENTRIES = 64,
    parameter int          TAG_BITS    = 8,
    parameter int          FETCH_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] FETCH_PC,
    input  logic        cache_stall,
    input  logic        hazard_stall,
    input  logic        flush,
    input  logic        branch_result,
    input  logic [31:0] RECOVER_TAKEN,
    input  logic [31:0] RECOVER_NOT_TAKEN,
    input  logic        bpt_write_enable,
    input  logic [31:0] BPT_WRITE_PC,
    input  logic [31:0] BPT_TARGET,
    input  logic        bpt_taken,
    output logic        out_valid,
    output logic [31:0] REG_PC,
    output logic [31:0] REG_INSTRUCTION,
    output logic        reg_prediction
);

    localparam int                PTR_W     = $clog2(FETCH_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FETCH_DEPTH);

    logic [31:0]      pc_q,    pc_d;
    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    fq_entry_t        fq_q [FETCH_DEPTH];
    fq_entry_t        head_entry;

    logic        push;
    logic        pop;
    logic        full;
    logic        pred_taken;
    logic        btb_hit;
    logic        btb_taken;
    logic [31:0] btb_target;

    fetch_btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .TAG_BITS    (TAG_BITS)
    ) u_btb (
        .clk         (clk),
        .rst_n       (reset),
        .rd_pc_i     (pc_q),
        .rd_hit_o    (btb_hit),
        .rd_taken_o  (btb_taken),
        .rd_target_o (btb_target),
        .wr_en_i     (bpt_write_enable),
        .wr_pc_i     (BPT_WRITE_PC),
        .wr_target_i (BPT_TARGET),
        .wr_taken_i  (bpt_taken)
    );

    assign FETCH_PC  = pc_q;
    assign full      = (count_q == DEPTH_CNT);
    assign out_valid = (count_q != '0);

    // BTB direction only matters for words that really are conditional branches.
    assign pred_taken = is_branch(INSTRUCTION) && btb_hit && (btb_taken == TAKEN);

    // Next PC and queue bookkeeping; flush overrides stalls, full gates push.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (flush) begin
            pc_d    = branch_result ? RECOVER_TAKEN : RECOVER_NOT_TAKEN;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (!cache_stall) begin
            push = !full;
            pop  = out_valid && !hazard_stall;
            if (push) begin
                pc_d   = pred_taken ? btb_target : (pc_q + 32'd4);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // PC and queue control state; async reset empties the queue at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue payload needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_q[tail_q] <= '{pc: pc_q, instr: INSTRUCTION, pred: pred_taken};
        end
    end

    assign head_entry      = fq_q[head_q];
    assign REG_PC          = out_valid ? head_entry.pc    : 32'd0;
    assign REG_INSTRUCTION = out_valid ? head_entry.instr : NOP;
    assign reg_prediction  = out_valid ? head_entry.pred  : 1'b0;

endmodule

// File: tb/tb_fetch_gen2.sv
// Self-checking bench for fetch_gen2: scoreboard of expected queue-head entries
// plus direct checks of reset, stall, flush and BTB behaviour.
`timescale 1ns/1ps
module tb_fetch_gen2;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] BEQ_WORD = 32'h1022_0004;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] INSTRUCTION;
    logic [31:0] FETCH_PC;
    logic        cache_stall;
    logic        hazard_stall;
    logic        flush;
    logic        branch_result;
    logic [31:0] RECOVER_TAKEN;
    logic [31:0] RECOVER_NOT_TAKEN;
    logic        bpt_write_enable;
    logic [31:0] BPT_WRITE_PC;
    logic [31:0] BPT_TARGET;
    logic        bpt_taken;
    logic        out_valid;
    logic [31:0] REG_PC;
    logic [31:0] REG_INSTRUCTION;
    logic        reg_prediction;

    logic beq_en;
    exp_t sb[$];
    int   n_vec;
    int   n_err;

    fetch_gen2 #(
        .BTB_ENTRIES (64),
        .TAG_BITS    (8),
        .FETCH_DEPTH (4),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .INSTRUCTION       (INSTRUCTION),
        .FETCH_PC          (FETCH_PC),
        .cache_stall       (cache_stall),
        .hazard_stall      (hazard_stall),
        .flush             (flush),
        .branch_result     (branch_result),
        .RECOVER_TAKEN     (RECOVER_TAKEN),
        .RECOVER_NOT_TAKEN (RECOVER_NOT_TAKEN),
        .bpt_write_enable  (bpt_write_enable),
        .BPT_WRITE_PC      (BPT_WRITE_PC),
        .BPT_TARGET        (BPT_TARGET),
        .bpt_taken         (bpt_taken),
        .out_valid         (out_valid),
        .REG_PC            (REG_PC),
        .REG_INSTRUCTION   (REG_INSTRUCTION),
        .reg_prediction    (reg_prediction)
    );

    // Instruction memory: ADDI-style words tagged with their address, optional BEQ at 0x20.
    function automatic logic [31:0] imem(input logic [31:0] pc, input logic b);
        if (b && (pc == 32'h20)) return BEQ_WORD;
        return 32'h2000_0000 | {16'h0, pc[15:0]};
    endfunction

    assign INSTRUCTION = imem(FETCH_PC, beq_en);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        cache_stall       = 1'b0;
        hazard_stall      = 1'b0;
        flush             = 1'b0;
        branch_result     = 1'b0;
        RECOVER_TAKEN     = 32'h0;
        RECOVER_NOT_TAKEN = 32'h0;
        bpt_write_enable  = 1'b0;
        BPT_WRITE_PC      = 32'h0;
        BPT_TARGET        = 32'h0;
        bpt_taken         = 1'b0;
        beq_en            = 1'b0;
    endtask

    // Reset for two edges, release 1ns after a rising edge.
    task automatic do_reset(input logic hz);
        idle_inputs();
        hazard_stall = hz;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic btb_write(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        bpt_write_enable = 1'b1;
        BPT_WRITE_PC     = pc;
        BPT_TARGET       = tgt;
        bpt_taken        = tk;
        @(posedge clk);
        #1 bpt_write_enable = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] addr);
        flush             = 1'b1;
        branch_result     = 1'b0;
        RECOVER_NOT_TAKEN = addr;
        RECOVER_TAKEN     = 32'hDEAD_0000;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_vec += 5;
        if (FETCH_PC !== RESET_PC) begin n_err++; $display("FAIL reset_fetch_pc: got %h want %h", FETCH_PC, RESET_PC); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (REG_PC !== 32'h0) begin n_err++; $display("FAIL reset_reg_pc: got %h want 0", REG_PC); end
        if (REG_INSTRUCTION !== NOP_WORD) begin n_err++; $display("FAIL reset_instr: got %h want %h", REG_INSTRUCTION, NOP_WORD); end
        if (reg_prediction !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", reg_prediction); end
    endtask

    task automatic test_sequence();
        exp_t e;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) sb.push_back('{pc: 32'(4*i), instr: imem(32'(4*i), 1'b0), pred: 1'b0});
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                n_vec++;
                if (REG_PC !== e.pc || REG_INSTRUCTION !== e.instr || reg_prediction !== e.pred) begin
                    n_err++;
                    $display("FAIL seq_pop: got pc=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                             REG_PC, REG_INSTRUCTION, reg_prediction, e.pc, e.instr, e.pred);
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL seq_timeout: %0d entries left want 0", sb.size()); sb.delete(); end
        n_vec++;
        if (FETCH_PC !== 32'd16) begin n_err++; $display("FAIL seq_fetch_pc: got %h want 00000010", FETCH_PC); end
    endtask

    task automatic test_hazard_full();
        exp_t e;
        do_reset(1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_vec += 3;
        if (FETCH_PC !== 32'd16) begin n_err++; $display("FAIL full_fetch_pc: got %h want 00000010", FETCH_PC); end
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", out_valid); end
        if (REG_PC !== 32'd0) begin n_err++; $display("FAIL full_head: got %h want 0", REG_PC); end
        @(posedge clk);
        #1 hazard_stall = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back('{pc: 32'(4*i), instr: imem(32'(4*i), 1'b0), pred: 1'b0});
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                n_vec++;
                if (REG_PC !== e.pc || REG_INSTRUCTION !== e.instr) begin
                    n_err++;
                    $display("FAIL drain_pop: got pc=%h instr=%h want pc=%h instr=%h", REG_PC, REG_INSTRUCTION, e.pc, e.instr);
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL drain_timeout: %0d entries left want 0", sb.size()); sb.delete(); end
        @(negedge clk);
        n_vec++;
        if (REG_PC !== 32'd16) begin n_err++; $display("FAIL drain_next: got %h want 00000010", REG_PC); end
    endtask

    task automatic test_cache_stall();
        do_reset(1'b0);
        repeat (3) @(posedge clk);
        #1 cache_stall = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec += 3;
        if (FETCH_PC !== 32'd12) begin n_err++; $display("FAIL cstall_fetch_pc: got %h want 0000000c", FETCH_PC); end
        if (REG_PC !== 32'd8) begin n_err++; $display("FAIL cstall_head: got %h want 00000008", REG_PC); end
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL cstall_valid: got %b want 1", out_valid); end
        @(posedge clk);
        #1 cache_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec += 2;
        if (REG_PC !== 32'd12) begin n_err++; $display("FAIL cstall_resume_head: got %h want 0000000c", REG_PC); end
        if (FETCH_PC !== 32'd16) begin n_err++; $display("FAIL cstall_resume_pc: got %h want 00000010", FETCH_PC); end
    endtask

    task automatic test_btb_predict();
        exp_t e;
        logic        nt_pred;
        logic [31:0] nt_next;
        do_reset(1'b0);
        @(posedge clk);
        #1;
        btb_write(32'h20, 32'h100, 1'b1);
        btb_write(32'h20, 32'h100, 1'b1);
        beq_en = 1'b1;
        flush_to(32'h20);
        sb.push_back('{pc: 32'h20, instr: BEQ_WORD, pred: 1'b1});
        sb.push_back('{pc: 32'h100, instr: imem(32'h100, 1'b1), pred: 1'b0});
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 20 && sb.size() > 0; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    e = sb.pop_front();
                    n_vec++;
                    if (REG_PC !== e.pc || REG_INSTRUCTION !== e.instr || reg_prediction !== e.pred) begin
                        n_err++;
                        $display("FAIL btb_pop%0d: got pc=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                                 pass, REG_PC, REG_INSTRUCTION, reg_prediction, e.pc, e.instr, e.pred);
                    end
                end
            end
            n_vec++;
            if (sb.size() != 0) begin n_err++; $display("FAIL btb_timeout%0d: %0d entries left want 0", pass, sb.size()); sb.delete(); end
            if (pass == 0) begin
                @(posedge clk);
                #1;
                btb_write(32'h20, 32'h100, 1'b0);
`ifdef FETCH_BTB_HYSTERESIS_EN
                nt_pred = 1'b1;
                nt_next = 32'h100;
`else
                nt_pred = 1'b0;
                nt_next = 32'h24;
`endif
                flush_to(32'h20);
                sb.push_back('{pc: 32'h20, instr: BEQ_WORD, pred: nt_pred});
                sb.push_back('{pc: nt_next, instr: imem(nt_next, 1'b1), pred: 1'b0});
            end
        end
    endtask

    task automatic test_flush(input logic cs, input logic br, input logic [31:0] addr);
        do_reset(1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
        flush             = 1'b1;
        cache_stall       = cs;
        branch_result     = br;
        RECOVER_TAKEN     = br ? addr : 32'hBAD0_0000;
        RECOVER_NOT_TAKEN = br ? 32'hBAD4_0000 : addr;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        cache_stall = 1'b0;
        @(negedge clk);
        n_vec += 4;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid cs=%b br=%b: got %b want 0", cs, br, out_valid); end
        if (REG_INSTRUCTION !== NOP_WORD) begin n_err++; $display("FAIL flush_instr cs=%b br=%b: got %h want %h", cs, br, REG_INSTRUCTION, NOP_WORD); end
        if (REG_PC !== 32'h0) begin n_err++; $display("FAIL flush_reg_pc cs=%b br=%b: got %h want 0", cs, br, REG_PC); end
        if (FETCH_PC !== addr) begin n_err++; $display("FAIL flush_fetch_pc cs=%b br=%b: got %h want %h", cs, br, FETCH_PC, addr); end
    endtask

    task automatic test_alias();
        exp_t e;
        do_reset(1'b0);
        @(posedge clk);
        #1;
        btb_write(32'h20, 32'h100, 1'b1);
        btb_write(32'h20 + 32'(4*64), 32'h200, 1'b1);
        beq_en = 1'b1;
        flush_to(32'h20);
        sb.push_back('{pc: 32'h20, instr: BEQ_WORD, pred: 1'b0});
        sb.push_back('{pc: 32'h24, instr: imem(32'h24, 1'b1), pred: 1'b0});
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                n_vec++;
                if (REG_PC !== e.pc || reg_prediction !== e.pred) begin
                    n_err++;
                    $display("FAIL alias_pop: got pc=%h pred=%b want pc=%h pred=%b", REG_PC, reg_prediction, e.pc, e.pred);
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL alias_timeout: %0d entries left want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset(1'b1);
        btb_write(32'h20, 32'h100, 1'b1);
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        if (REG_PC !== 32'h0) begin n_err++; $display("FAIL areset_reg_pc: got %h want 0", REG_PC); end
        if (REG_INSTRUCTION !== NOP_WORD) begin n_err++; $display("FAIL areset_instr: got %h want %h", REG_INSTRUCTION, NOP_WORD); end
        if (reg_prediction !== 1'b0) begin n_err++; $display("FAIL areset_pred: got %b want 0", reg_prediction); end
        if (FETCH_PC !== RESET_PC) begin n_err++; $display("FAIL areset_fetch_pc: got %h want %h", FETCH_PC, RESET_PC); end
        @(posedge clk);
        #1;
        reset        = 1'b1;
        hazard_stall = 1'b0;
        beq_en       = 1'b1;
        flush_to(32'h20);
        sb.push_back('{pc: 32'h20, instr: BEQ_WORD, pred: 1'b0});
        sb.push_back('{pc: 32'h24, instr: imem(32'h24, 1'b1), pred: 1'b0});
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                n_vec++;
                if (REG_PC !== e.pc || reg_prediction !== e.pred) begin
                    n_err++;
                    $display("FAIL areset_btb_pop: got pc=%h pred=%b want pc=%h pred=%b", REG_PC, reg_prediction, e.pc, e.pred);
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL areset_timeout: %0d entries left want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_sequence();
        test_hazard_full();
        test_cache_stall();
        test_btb_predict();
        test_flush(1'b0, 1'b0, 32'h40);
        test_flush(1'b1, 1'b0, 32'h40);
        test_flush(1'b0, 1'b1, 32'h80);
        test_alias();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_gen2.md
Name: fetch_gen2

Overview:
Second-generation FETCH stage. Holds the fetch PC and predicts BEQ/BNE direction and target from an internal, tagged, parametrised branch target buffer (BTB) with saturating counters. Fetched instructions go into a FETCH_DEPTH-entry fetch queue, so decode-side stalls do not stall the PC until the queue fills. Sits between instruction memory and DECODE; mispredict recovery arrives from MEMORY as flush/branch_result.

Parameters:
BTB_ENTRIES, 64, number of BTB entries; power of 2, >=2
TAG_BITS, 8, stored tag width taken from PC above the index bits
FETCH_DEPTH, 4, fetch-queue entries; power of 2, >=2
RESET_PC, 32'd0, PC loaded on reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
INSTRUCTION  in  32  instruction memory data for FETCH_PC, valid in the same cycle
FETCH_PC  out  32  current fetch address to instruction memory
cache_stall  in  1  imem/dmem miss: no push into the queue, no pop from it, PC held
hazard_stall  in  1  DECODE cannot accept: no pop from the queue
flush  in  1  mispredict recovery request from MEMORY
branch_result  in  1  resolved direction; selects the recovery address when flush=1
RECOVER_TAKEN  in  32  recovery PC if actually taken
RECOVER_NOT_TAKEN  in  32  recovery PC if actually not taken
bpt_write_enable  in  1  BTB update strobe from resolved branch
BPT_WRITE_PC  in  32  PC of the resolved branch
BPT_TARGET  in  32  resolved taken target
bpt_taken  in  1  resolved direction used for the BTB update
out_valid  out  1  queue head valid
REG_PC  out  32  PC of the queue head
REG_INSTRUCTION  out  32  queue-head instruction; NOP when out_valid=0
reg_prediction  out  1  predicted direction of the queue head

Behaviour:
- Reset (async assert, sync release):
  - FETCH_PC=RESET_PC.
  - Queue empty; out_valid=0, REG_PC=0, REG_INSTRUCTION=NOP, reg_prediction=0.
  - All BTB valid bits cleared.
  - Reset mid-operation discards queue and BTB contents.
- BTB addressing: index = PC[log2(BTB_ENTRIES)+1:2]; tag = next TAG_BITS PC bits.
  - Hit = valid && tag match.
  - Prediction = hit && counter[MSB]; predicted target = stored target.
- Branch detect: is_branch = opcode is BEQ or BNE. A prediction counts only when is_branch=1; otherwise the pushed prediction bit is 0.
- Priority each cycle: reset > flush > cache_stall > normal.
- flush:
  - FETCH_PC <= branch_result ? RECOVER_TAKEN : RECOVER_NOT_TAKEN.
  - Queue emptied; no push, no pop. Outputs show invalid/NOP the next cycle.
- cache_stall: FETCH_PC, queue and outputs hold.
- Normal cycle:
  - push = !full; pop = out_valid && !hazard_stall.
  - On push, {FETCH_PC, INSTRUCTION, prediction} is enqueued and FETCH_PC advances: predicted-taken branch -> BTB target, else FETCH_PC+4 (mod 2^32).
  - When full, FETCH_PC holds. Push is gated by registered full only (no same-cycle pop bypass).
  - Push and pop in the same cycle leave the count unchanged.
- Queue: circular pointers wrap modulo FETCH_DEPTH; count 0..FETCH_DEPTH. Outputs reflect the head registers, one cycle after push.
- BTB update (bpt_write_enable, independent of stalls, suppressed only by reset):
  - Hit: counter saturating +/-1 per bpt_taken (2'b11 max, 2'b00 min); target <= BPT_TARGET.
  - Miss: allocate/replace the entry: tag written, valid=1, target=BPT_TARGET, counter = bpt_taken ? 2'b10 : 2'b01.
  - Write and read to the same index in the same cycle: read sees the old contents.

Optional Feature:
FETCH_BTB_HYSTERESIS_EN
- Defined: 2-bit saturating counters as above.
- Undefined: 1-bit counters.
  - Hit: bit <= bpt_taken. Miss allocate: bit <= bpt_taken.
  - Prediction = hit && bit.
  - Port list unchanged.

Decomposition:
- Shared package/header (extends opcode.v): OPCODE_BEQ, OPCODE_BNE, NOP, TAKEN/NOT_TAKEN, counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11).
- One sub-module, fetch_btb: storage, tag compare, counter update.
  - Combinational read port; synchronous write port; async active-low reset clears valids.

Test Plan:
- Reset low, then released; 4 non-branch words; hazard_stall=0 -> REG_PC sequence 0,4,8,12 with out_valid from the second cycle on; FETCH_PC 16 afterwards.
- hazard_stall=1 held; FETCH_DEPTH=4 -> exactly 4 pushes, FETCH_PC frozen at 16; release -> PCs 0,4,8,12 pop in order, with no loss or duplication.
- BTB update PC=0x20, target 0x100, taken, twice; then fetch BEQ at 0x20 -> reg_prediction=1, next pushed PC 0x100.
  - Same flow with FETCH_BTB_HYSTERESIS_EN undefined and one not-taken update -> predicts not-taken, next PC 0x24.
- flush=1, branch_result=0, RECOVER_NOT_TAKEN=0x40 with queue holding 3 entries -> next cycle out_valid=0, REG_INSTRUCTION=NOP, FETCH_PC=0x40.
  - Simultaneous cache_stall=1 -> flush still wins.
- Aliasing: update PC 0x20, then PC 0x20+4*BTB_ENTRIES (same index, different tag) -> fetching 0x20 misses, predicts not-taken.
- Async reset asserted mid-cycle while queue is full -> outputs clear immediately, without waiting for a clock edge; BTB valids cleared.
